// File: rtl/pio_button_in.sv
// pio_button_in: Avalon-MM input PIO for push-buttons/switches.
// Two-flop synchronizer, optional per-bit debounce, per-bit edge capture
// (write-1-to-clear) and a maskable level interrupt.
// Build option: define PIO_BUTTON_IN_DEBOUNCE_EN to build the per-bit
// debounce counters; otherwise the synchronized value is accepted directly
// and DEBOUNCE_CYCLES has no effect.
//
// Register map (word address):
//   0 DATA  RO   debounced value
//   1 RAW   RO   synchronized, undebounced value
//   2 MASK  RW   interrupt enable per bit
//   3 EDGE  W1C  edge capture per bit
module pio_button_in #(
  parameter int          WIDTH           = 4,
  parameter int          EDGE_TYPE       = 0,
  parameter int          DEBOUNCE_CYCLES = 8,
  parameter logic [31:0] RESET_MASK      = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] clr_s;
  logic             wr_en_s;
  logic [31:0]      readdata_s;

  // Bits of writedata above WIDTH carry no meaning for this block.
  logic unused_wdata_s;
  assign unused_wdata_s = ^writedata;

  // Two-flop synchronizer for the asynchronous external inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_BUTTON_IN_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per-bit debounce: accept a change only after it has been stable long enough.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Without debounce the synchronized value is accepted every cycle.
  always_comb begin
    stable_d = sync2_q;
  end
`endif

  // Edge events are the cycles where the accepted value changes.
  always_comb begin
    rise_s = stable_d & ~stable_q;
    fall_s = ~stable_d & stable_q;
    case (EDGE_TYPE)
      32'sd0:  set_s = rise_s;
      32'sd1:  set_s = fall_s;
      default: set_s = rise_s | fall_s;
    endcase
  end

  // Bus write decode: MASK load and EDGE write-1-to-clear; a new edge beats a clear.
  always_comb begin
    wr_en_s = chipselect & ~write_n;
    if (wr_en_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    if (wr_en_s && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    edge_d = (edge_q & ~clr_s) | set_s;
  end

  // Accepted value, interrupt mask and edge capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      mask_q   <= RESET_MASK[WIDTH-1:0];
      edge_q   <= '0;
    end else begin
      stable_q <= stable_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
    end
  end

  // Zero-wait-state read mux, zero-extended to 32 bits.
  always_comb begin
    readdata_s = '0;
    case (address)
      2'd0:    readdata_s[WIDTH-1:0] = stable_q;
      2'd1:    readdata_s[WIDTH-1:0] = sync2_q;
      2'd2:    readdata_s[WIDTH-1:0] = mask_q;
      2'd3:    readdata_s[WIDTH-1:0] = edge_q;
      default: readdata_s = '0;
    endcase
  end

  assign readdata = readdata_s;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_button_in.sv
// tb_pio_button_in: directed, table-driven bench for pio_button_in.
// Three instances share clock, reset, bus and inputs and differ only in
// EDGE_TYPE (0 rising, 1 falling, 2 any), so one stimulus stream exercises
// all three capture modes.
module tb_pio_button_in;

`ifdef PIO_BUTTON_IN_DEBOUNCE_EN
  localparam int LAT = 9;   // input change at edge n -> DATA at n+1+DEBOUNCE_CYCLES
`else
  localparam int LAT = 2;   // input change at edge n -> DATA at n+2
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] in_v;
    logic [3:0] mask_v;
    logic [3:0] e_rise;
    logic [3:0] e_fall;
    logic [3:0] e_any;
  } vec_t;

  vec_t vecs [8];

  pio_button_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8), .RESET_MASK(32'h5)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  pio_button_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(8), .RESET_MASK(32'h5)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  pio_button_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8), .RESET_MASK(32'h5)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  // Free-running clock, 20 ns period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input int d, input logic [1:0] a,
                         input logic [31:0] exp);
    logic [31:0] v;
    address = a;
    #1;
    if (d == 0)      v = rd0;
    else if (d == 1) v = rd1;
    else             v = rd2;
    chk(nm, v, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            in     mask   rise   fall   any
    vecs[0] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    vecs[1] = '{4'h3, 4'h1, 4'h2, 4'h0, 4'h2};
    vecs[2] = '{4'hA, 4'h8, 4'h8, 4'h1, 4'h9};
    vecs[3] = '{4'h5, 4'h2, 4'h5, 4'hA, 4'hF};
    vecs[4] = '{4'h0, 4'hF, 4'h0, 4'h5, 4'h5};
    vecs[5] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    vecs[6] = '{4'h6, 4'hF, 4'h0, 4'h9, 4'h9};
    vecs[7] = '{4'h0, 4'h0, 4'h0, 4'h6, 4'h6};

    reset_n    = 1'b0;
    in_port    = 4'h0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;

    // Reset values while reset is held.
    repeat (3) step();
    chk_reg("rst_data", 0, 2'd0, 32'h0);
    chk_reg("rst_raw",  0, 2'd1, 32'h0);
    chk_reg("rst_edge", 0, 2'd3, 32'h0);
    chk_reg("rst_mask", 0, 2'd2, 32'h5);
    chk("rst_irq", {31'h0, irq0}, 32'h0);
    reset_n = 1'b1;
    repeat (3) step();

    // Latency of a single rising input (bit 0).
    in_port = 4'h1;
    step();                                   // edge n
    chk_reg("lat_raw_n", 0, 2'd1, 32'h0);
    step();                                   // edge n+1
    chk_reg("lat_raw_n1", 0, 2'd1, 32'h1);
    repeat (LAT - 2) step();                  // edge n+LAT-1
    chk_reg("lat_data_early", 0, 2'd0, 32'h0);
    step();                                   // edge n+LAT
    chk_reg("lat_data", 0, 2'd0, 32'h1);
    chk_reg("lat_edge", 0, 2'd3, 32'h1);
    chk("lat_irq", {31'h0, irq0}, 32'h1);

`ifdef PIO_BUTTON_IN_DEBOUNCE_EN
    // A 7-cycle pulse on bit 1 must never be accepted.
    wr(2'd3, 32'hF);
    in_port = 4'h3;
    repeat (7) step();
    in_port = 4'h1;
    repeat (12) step();
    chk_reg("glitch_data", 0, 2'd0, 32'h1);
    chk_reg("glitch_edge", 2, 2'd3, 32'h0);
`endif

    // Reset asserted mid-update clears accepted value and capture at once.
    in_port = 4'hF;
    repeat (LAT) step();
    reset_n = 1'b0;
    #1;
    chk_reg("midrst_data", 0, 2'd0, 32'h0);
    chk_reg("midrst_edge", 2, 2'd3, 32'h0);
    in_port = 4'h0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();

    // W1C: EDGE=B, clear bits 1:0, irq follows MASK.
    in_port = 4'hB;
    repeat (LAT + 2) step();
    chk_reg("w1c_pre", 0, 2'd3, 32'hB);
    chk("w1c_pre_irq", {31'h0, irq0}, 32'h1);
    wr(2'd3, 32'h3);
    chk_reg("w1c_post", 0, 2'd3, 32'h8);
    chk("w1c_irq_masked", {31'h0, irq0}, 32'h0);
    wr(2'd2, 32'h8);
    chk("w1c_irq_unmasked", {31'h0, irq0}, 32'h1);

    // Clear of bit 0 on the same edge as a new rising event: event wins.
    in_port = 4'hA;
    repeat (LAT + 2) step();
    wr(2'd3, 32'hF);
    chk_reg("coin_pre", 0, 2'd3, 32'h0);
    in_port = 4'hB;
    repeat (LAT) step();
    wr(2'd3, 32'h1);                          // write lands on edge n+LAT
    chk_reg("coin_rise", 0, 2'd3, 32'h1);
    chk_reg("coin_fall", 1, 2'd3, 32'h0);
    wr(2'd3, 32'h1);
    chk_reg("coin_clear", 0, 2'd3, 32'h0);

    // Bit 2 toggled 0->1->0 with a clear between events.
    in_port = 4'h0;
    repeat (LAT + 2) step();
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h0);
    in_port = 4'h4;
    repeat (LAT + 2) step();
    chk_reg("tog_rise_r", 0, 2'd3, 32'h4);
    chk_reg("tog_rise_f", 1, 2'd3, 32'h0);
    chk_reg("tog_rise_a", 2, 2'd3, 32'h4);
    wr(2'd3, 32'hF);
    in_port = 4'h0;
    repeat (LAT + 2) step();
    chk_reg("tog_fall_r", 0, 2'd3, 32'h0);
    chk_reg("tog_fall_f", 1, 2'd3, 32'h4);
    chk_reg("tog_fall_a", 2, 2'd3, 32'h4);

    // Upper bits read as zero; writes to DATA and RAW are ignored.
    in_port = 4'h6;
    repeat (LAT + 2) step();
    wr(2'd2, 32'hFFFF_FFFF);
    chk_reg("mask_width", 0, 2'd2, 32'hF);
    wr(2'd3, 32'hF);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    chk_reg("ro_data", 0, 2'd0, 32'h6);
    chk_reg("ro_raw",  0, 2'd1, 32'h6);
    chk_reg("ro_mask", 0, 2'd2, 32'hF);
    chk_reg("ro_edge", 0, 2'd3, 32'h0);
    in_port = 4'h0;
    repeat (LAT + 2) step();

    // Table-driven: each vector starts from the previous input value.
    for (int i = 0; i < 8; i++) begin
      wr(2'd3, 32'hF);
      wr(2'd2, {28'h0, vecs[i].mask_v});
      in_port = vecs[i].in_v;
      repeat (LAT + 2) step();
      chk_reg($sformatf("v%0d_data", i), 0, 2'd0, {28'h0, vecs[i].in_v});
      chk_reg($sformatf("v%0d_raw", i),  0, 2'd1, {28'h0, vecs[i].in_v});
      chk_reg($sformatf("v%0d_rise", i), 0, 2'd3, {28'h0, vecs[i].e_rise});
      chk_reg($sformatf("v%0d_fall", i), 1, 2'd3, {28'h0, vecs[i].e_fall});
      chk_reg($sformatf("v%0d_any", i),  2, 2'd3, {28'h0, vecs[i].e_any});
      chk($sformatf("v%0d_irq_r", i), {31'h0, irq0},
          {31'h0, |(vecs[i].e_rise & vecs[i].mask_v)});
      chk($sformatf("v%0d_irq_f", i), {31'h0, irq1},
          {31'h0, |(vecs[i].e_fall & vecs[i].mask_v)});
      chk($sformatf("v%0d_irq_a", i), {31'h0, irq2},
          {31'h0, |(vecs[i].e_any & vecs[i].mask_v)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_button_in.md
# pio_button_in

Avalon-MM slave input PIO that samples an asynchronous push-button/switch bus, synchronizes and optionally debounces it, captures edges per bit, and raises a maskable level interrupt. It is the input-side counterpart of the system's LED output PIO. It sits on the same Avalon bus and register-map style: 2-bit word address, zero-wait-state combinational reads, writes qualified by chipselect and ~write_n.

## Interface
- WIDTH, 4: number of input bits (1..32).
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge captured.
- DEBOUNCE_CYCLES, 8: consecutive stable clk cycles required before a synchronized change is accepted (>= 1; only used with debounce compiled in).
- RESET_MASK, 0: reset value of the interrupt mask register.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset; clock clk.
- address  in  2  word register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, zero-extended, combinational from address.
- irq  out  1  level interrupt, active high.

## Operation
- Register map:
  - 0 DATA, RO: debounced value `stable`.
  - 1 RAW, RO: synchronized undebounced value `sync2`.
  - 2 MASK, RW: irq enable per bit.
  - 3 EDGE, R/W1C: edge capture.
- Writes occur when chipselect && ~write_n:
  - Writes to 0 and 1 are ignored.
  - A write to 2 loads writedata[WIDTH-1:0].
  - A write to 3 clears every bit whose writedata bit is 1.
- Reads have no side effects. Upper readdata bits [31:WIDTH] are 0.
- Synchronizer: two flops, sync1 <= in_port, sync2 <= sync1.
- Stable update, per bit, without debounce: stable <= sync2 every cycle.
- Stable update, per bit, with debounce:
  - Counter cnt of width clog2(DEBOUNCE_CYCLES)+1.
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches stable.
- Edge detect, per bit: an edge event is any clock where stable changes.
  - Rising means 0->1, falling means 1->0.
  - EDGE_TYPE selects which events set the capture bit.
- Capture bits hold until cleared by software. On the same cycle as a W1C clear, a new edge event wins and the bit stays 1.
- irq = |(EDGE & MASK), combinational from registers.

## Timing
- Reset values: sync1, sync2, stable, cnt, EDGE all 0; MASK = RESET_MASK; irq 0; readdata follows address (DATA = 0).
- Input change sampled at clk edge n: sync1 at n, sync2 at n+1.
- No debounce: stable and EDGE update at n+2, irq at n+2 (combinational after the register).
- Debounce: stable and EDGE update at n+1+DEBOUNCE_CYCLES.
- Read latency 0: readdata is valid in the cycle address is presented.
- MASK and EDGE writes take effect on the write clock edge, so irq changes after that edge.
- An input held high through reset is seen as a rising edge after release. Software clears EDGE after init.
- Asserting reset mid-count clears cnt, stable and EDGE immediately.

## Configuration
- PIO_BUTTON_IN_DEBOUNCE_EN defined: per-bit debounce counters are built and DEBOUNCE_CYCLES applies.
- Macro undefined: no counters; stable <= sync2 each cycle; DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset: WIDTH=4, RESET_MASK=4'h5. Hold reset_n=0 with in_port=0. Required: readdata 0 at addresses 0, 1 and 3; 5 at address 2; irq=0.
- Debounce, DEBOUNCE_CYCLES=8, EDGE_TYPE=0, MASK=4'h1:
  - in_port[0] 0->1 at edge n: DATA reads 1 first after edge n+9, EDGE=1, irq=1.
  - A 7-cycle pulse leaves DATA=0 and EDGE=0.
- W1C: EDGE=4'hB, write 4'h3 to address 3. Required: EDGE=4'h8; irq follows MASK.
  - A clear of bit 0 coinciding with a new rising edge on bit 0 leaves bit 0 = 1.
- EDGE_TYPE=2: toggle in_port[2] 0->1->0 with clear between events. Required: both transitions set EDGE[2].
- EDGE_TYPE=1: a rising edge leaves EDGE=0; a falling edge sets it.
- Without the macro: in_port change at edge n gives DATA updated at n+2. RAW tracks sync2 at n+1. Writes to addresses 0 and 1 change nothing.
